// File: rtl/irq_ctl_if.sv
// rtl/irq_ctl_if.sv - CPU bus bundle for the interrupt controller register window
interface irq_ctl_if;
    logic [15:0] AD;
    logic [7:0]  DI;
    logic [7:0]  DO;
    logic        WE;
    logic        RDY;

    modport master (output AD, output DI, output WE, output RDY, input DO);
    modport slave  (input AD, input DI, input WE, input RDY, output DO);
endinterface

// File: rtl/irq_ctl.sv
// rtl/irq_ctl.sv - 65C02 interrupt controller: level/edge IRQ merge, NMI latch, register window
module irq_ctl #(
    parameter int          CHANNELS = 8,
    parameter logic [15:0] BASE     = 16'hFFE0
) (
    input  logic                clk,
    input  logic                RST,
    irq_ctl_if.slave            bus,
    input  logic [CHANNELS-1:0] SRC,
    input  logic                NMI_IN,
    output logic                IRQ,
    output logic                NMI
);

    logic [CHANNELS-1:0] src_s1, src_s2, src_s3;
    logic                nmi_s1, nmi_s2, nmi_s3;
    logic [CHANNELS-1:0] mask_q, mode_q, edge_latch;
    logic                nmi_latch;

    logic [CHANNELS-1:0] src_rise;
    logic                nmi_rise;
    logic [CHANNELS-1:0] pending, enabled, lowest;
    logic [CHANNELS-1:0] w1c_clr, ack_clr;
    logic                nmi_clr;
    logic                any_enabled;
    logic [2:0]          idx;
    logic                sel, rd, wr;
    logic [2:0]          off;
    logic [7:0]          rdata;

    assign sel = (bus.AD[15:3] == BASE[15:3]);
    assign off = bus.AD[2:0];
    assign rd  = sel && !bus.WE && bus.RDY;
    assign wr  = sel && bus.WE && bus.RDY;

    assign src_rise    = src_s2 & ~src_s3;
    assign nmi_rise    = nmi_s2 & ~nmi_s3;
    assign pending     = (mode_q & edge_latch) | (~mode_q & src_s2);
    assign enabled     = pending & mask_q;
    assign any_enabled = |enabled;
    // Isolates the lowest set bit: the priority winner as a one-hot vector.
    assign lowest      = enabled & (~enabled + 1'b1);

    assign w1c_clr = (wr && off == 3'd0) ? bus.DI[CHANNELS-1:0] : '0;
    assign ack_clr = (rd && off == 3'd3) ? (lowest & mode_q) : '0;
    assign nmi_clr = wr && off == 3'd4 && bus.DI[0];

    // Binary index of the highest-priority (lowest-numbered) enabled pending channel.
    always_comb begin
        idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                idx = 3'(i);
            end
        end
    end

    // Read data mux; bits above CHANNELS come out as zero through the size casts.
    always_comb begin
        rdata = 8'h00;
        case (off)
            3'd0: rdata = 8'(pending);
            3'd1: rdata = 8'(mask_q);
            3'd2: rdata = 8'(mode_q);
            3'd3: rdata = any_enabled ? {5'b0, idx} : 8'h80;
            3'd4: rdata = {7'b0, nmi_latch};
            default: rdata = 8'h00;
        endcase
    end

    // Two-flop synchronisers plus a third delayed flop for rising-edge detection.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            src_s1 <= '0;
            src_s2 <= '0;
            src_s3 <= '0;
            nmi_s1 <= 1'b0;
            nmi_s2 <= 1'b0;
            nmi_s3 <= 1'b0;
        end else begin
            src_s1 <= SRC;
            src_s2 <= src_s1;
            src_s3 <= src_s2;
            nmi_s1 <= NMI_IN;
            nmi_s2 <= nmi_s1;
            nmi_s3 <= nmi_s2;
        end
    end

    // Control registers, written only on a selected, ready bus write.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            mask_q <= '0;
            mode_q <= '0;
        end else if (wr) begin
            if (off == 3'd1) mask_q <= bus.DI[CHANNELS-1:0];
            if (off == 3'd2) mode_q <= bus.DI[CHANNELS-1:0];
        end
    end

    // Edge and NMI latches: a new edge wins over a same-cycle W1C or acknowledge;
    // edge latches are held clear for channels in level mode.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            edge_latch <= '0;
            nmi_latch  <= 1'b0;
        end else begin
            edge_latch <= mode_q & (src_rise | (edge_latch & ~w1c_clr & ~ack_clr));
            nmi_latch  <= nmi_rise | (nmi_latch & ~nmi_clr);
        end
    end

    // Registered CPU interrupt lines and synchronous-memory style read data.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            IRQ    <= 1'b0;
            NMI    <= 1'b0;
            bus.DO <= 8'h00;
        end else begin
            IRQ <= any_enabled;
            NMI <= nmi_latch;
            if (rd) bus.DO <= rdata;
        end
    end

endmodule

// File: tb/tb_irq_ctl.sv
// tb/tb_irq_ctl.sv - directed self-checking bench for irq_ctl
module tb_irq_ctl;
    localparam logic [15:0] BASE = 16'hFFE0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] src = 8'h00;
    logic       nmi_in = 1'b0;
    logic       irq, nmi;
    logic [7:0] rd_val;
    int         checks = 0;
    int         passes = 0;

    irq_ctl_if bus();

    irq_ctl #(.CHANNELS(8), .BASE(BASE)) dut (
        .clk    (clk),
        .RST    (rst),
        .bus    (bus.slave),
        .SRC    (src),
        .NMI_IN (nmi_in),
        .IRQ    (irq),
        .NMI    (nmi)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        bus.AD  = 16'h0000;
        bus.DI  = 8'h00;
        bus.WE  = 1'b0;
        bus.RDY = 1'b1;
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [7:0] data, input logic rdy = 1'b1);
        bus.AD  = BASE + 16'(off);
        bus.DI  = data;
        bus.WE  = 1'b1;
        bus.RDY = rdy;
        tick();
        bus_idle();
    endtask

    task automatic bus_read(input logic [2:0] off, output logic [7:0] data, input logic rdy = 1'b1);
        bus.AD  = BASE + 16'(off);
        bus.WE  = 1'b0;
        bus.RDY = rdy;
        tick();
        data = bus.DO;
        bus_idle();
    endtask

    task automatic test_reset();
        checks++;
        if (irq !== 1'b0 || nmi !== 1'b0 || bus.DO !== 8'h00)
            $display("FAIL reset_outputs: irq=%b nmi=%b do=%h, required 0 0 00", irq, nmi, bus.DO);
        else passes++;
        bus_read(3'd1, rd_val);
        checks++;
        if (rd_val !== 8'h00) $display("FAIL reset_mask: got %h, required 00", rd_val);
        else passes++;
        bus_read(3'd3, rd_val);
        checks++;
        if (rd_val !== 8'h80) $display("FAIL reset_vector: got %h, required 80", rd_val);
        else passes++;
    endtask

    task automatic test_edge_channel();
        bus_write(3'd2, 8'h08);
        bus_write(3'd1, 8'h08);
        src[3] = 1'b1;
        tick();            // edge k: stage 1 captures
        src[3] = 1'b0;
        tick(2);           // edge k+2: latch set, IRQ not yet
        checks++;
        if (irq !== 1'b0) $display("FAIL edge_irq_early: irq=%b, required 0", irq);
        else passes++;
        tick();            // edge k+3
        checks++;
        if (irq !== 1'b1) $display("FAIL edge_irq_rise: irq=%b, required 1", irq);
        else passes++;
        bus_read(3'd3, rd_val);
        checks++;
        if (rd_val !== 8'h03) $display("FAIL edge_vector: got %h, required 03", rd_val);
        else passes++;
        tick();
        checks++;
        if (irq !== 1'b0) $display("FAIL edge_irq_after_ack: irq=%b, required 0", irq);
        else passes++;
        bus_read(3'd3, rd_val);
        checks++;
        if (rd_val !== 8'h80) $display("FAIL edge_vector_empty: got %h, required 80", rd_val);
        else passes++;
    endtask

    task automatic test_priority_level();
        bus_write(3'd2, 8'h00);
        bus_write(3'd1, 8'h24);
        src = 8'h24;
        tick(3);
        for (int i = 0; i < 2; i++) begin
            bus_read(3'd3, rd_val);
            checks++;
            if (rd_val !== 8'h02) $display("FAIL prio_vector_%0d: got %h, required 02", i, rd_val);
            else passes++;
        end
        bus_read(3'd0, rd_val);
        checks++;
        if (rd_val !== 8'h24) $display("FAIL prio_status: got %h, required 24", rd_val);
        else passes++;
        src[2] = 1'b0;
        tick(2);
        bus_read(3'd3, rd_val);
        checks++;
        if (rd_val !== 8'h05) $display("FAIL prio_vector_after_drop: got %h, required 05", rd_val);
        else passes++;
        src = 8'h00;
        tick(3);
        checks++;
        if (irq !== 1'b0) $display("FAIL level_irq_fall: irq=%b, required 0", irq);
        else passes++;
    endtask

    task automatic test_set_beats_clear();
        bus_write(3'd2, 8'h01);
        bus_write(3'd1, 8'h01);
        src[0] = 1'b1;
        tick(2);                    // edges k, k+1
        bus_write(3'd0, 8'h01);     // W1C lands on edge k+2, same as the latch set
        bus_read(3'd0, rd_val);
        checks++;
        if (rd_val !== 8'h01) $display("FAIL setwin_status: got %h, required 01", rd_val);
        else passes++;
        checks++;
        if (irq !== 1'b1) $display("FAIL setwin_irq: irq=%b, required 1", irq);
        else passes++;
        bus_write(3'd0, 8'h01);
        bus_read(3'd0, rd_val);
        checks++;
        if (rd_val !== 8'h00) $display("FAIL w1c_status: got %h, required 00", rd_val);
        else passes++;
        checks++;
        if (irq !== 1'b0) $display("FAIL w1c_irq: irq=%b, required 0", irq);
        else passes++;
        src[0] = 1'b0;
        tick(3);
    endtask

    task automatic test_nmi();
        nmi_in = 1'b1;
        tick();
        nmi_in = 1'b0;
        tick(2);
        checks++;
        if (nmi !== 1'b0) $display("FAIL nmi_early: nmi=%b, required 0", nmi);
        else passes++;
        tick();
        checks++;
        if (nmi !== 1'b1) $display("FAIL nmi_rise: nmi=%b, required 1", nmi);
        else passes++;
        bus_read(3'd4, rd_val);
        checks++;
        if (rd_val !== 8'h01) $display("FAIL nmistat: got %h, required 01", rd_val);
        else passes++;
        bus_write(3'd4, 8'h01);
        tick();
        checks++;
        if (nmi !== 1'b0) $display("FAIL nmi_clear: nmi=%b, required 0", nmi);
        else passes++;
    endtask

    task automatic test_unmapped();
        bus_write(3'd5, 8'hFF);
        bus_read(3'd5, rd_val);
        checks++;
        if (rd_val !== 8'h00) $display("FAIL unmapped_read: got %h, required 00", rd_val);
        else passes++;
        bus_read(3'd1, rd_val);          // DO = 01 from set-beats-clear mask
        bus.AD = 16'h1002;               // outside window, same low offset as MODE
        bus.WE = 1'b0;
        tick();
        bus_idle();
        checks++;
        if (bus.DO !== 8'h01) $display("FAIL unselected_hold: do=%h, required 01", bus.DO);
        else passes++;
    endtask

    task automatic test_rdy_stall();
        bus_write(3'd2, 8'h08);
        bus_write(3'd1, 8'h08);
        src[3] = 1'b1;
        tick();
        src[3] = 1'b0;
        tick(3);
        bus_read(3'd1, rd_val);          // DO = 08
        bus_read(3'd3, rd_val, 1'b0);
        checks++;
        if (rd_val !== 8'h08) $display("FAIL stall_do_hold: do=%h, required 08", rd_val);
        else passes++;
        bus_write(3'd1, 8'h00, 1'b0);
        tick();
        checks++;
        if (irq !== 1'b1) $display("FAIL stall_irq_kept: irq=%b, required 1", irq);
        else passes++;
        bus_read(3'd1, rd_val);
        checks++;
        if (rd_val !== 8'h08) $display("FAIL stall_mask: got %h, required 08", rd_val);
        else passes++;
        bus_read(3'd0, rd_val);
        checks++;
        if (rd_val !== 8'h08) $display("FAIL stall_pending: got %h, required 08", rd_val);
        else passes++;
        bus_read(3'd3, rd_val);
        checks++;
        if (rd_val !== 8'h03) $display("FAIL stall_retry_vector: got %h, required 03", rd_val);
        else passes++;
        bus_write(3'd1, 8'h00);
        bus_read(3'd1, rd_val);
        checks++;
        if (rd_val !== 8'h00) $display("FAIL stall_retry_mask: got %h, required 00", rd_val);
        else passes++;
        checks++;
        if (irq !== 1'b0) $display("FAIL stall_retry_irq: irq=%b, required 0", irq);
        else passes++;
    endtask

    task automatic test_reset_mid();
        bus_write(3'd2, 8'h00);
        bus_write(3'd1, 8'hFF);
        src = 8'h01;
        nmi_in = 1'b1;
        tick(4);
        bus_read(3'd1, rd_val);
        checks++;
        if (irq !== 1'b1 || nmi !== 1'b1 || rd_val !== 8'hFF)
            $display("FAIL midreset_setup: irq=%b nmi=%b do=%h, required 1 1 ff", irq, nmi, rd_val);
        else passes++;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (irq !== 1'b0 || nmi !== 1'b0 || bus.DO !== 8'h00)
            $display("FAIL midreset_async: irq=%b nmi=%b do=%h, required 0 0 00", irq, nmi, bus.DO);
        else passes++;
        src = 8'h00;
        nmi_in = 1'b0;
        tick(2);
        rst = 1'b0;
        bus_read(3'd1, rd_val);
        checks++;
        if (rd_val !== 8'h00) $display("FAIL midreset_mask: got %h, required 00", rd_val);
        else passes++;
    endtask

    initial begin
        bus_idle();
        tick(2);
        rst = 1'b0;
        test_reset();
        test_edge_channel();
        test_priority_level();
        test_set_beats_clear();
        test_nmi();
        test_unmapped();
        test_rdy_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
